multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/mmio_decoder.sv | 17 +
 rtl/multicycle_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode constants, FSM state encoding, ALU-op codes and the
// instruction classifier shared by the multicycle controller files.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Only word-sized loads and stores are supported.
    localparam logic [2:0] F3_WORD   = 3'b010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_R       = 4'd1,
        CL_IALU    = 4'd2,
        CL_LOAD    = 4'd3,
        CL_STORE   = 4'd4,
        CL_BRANCH  = 4'd5,
        CL_JAL     = 4'd6,
        CL_JALR    = 4'd7,
        CL_UPPER   = 4'd8
    } inst_class_e;

    // Map an instruction word onto the class that drives routing and controls.
    // upper_en makes LUI/AUIPC legal; otherwise they classify as illegal.
    function automatic inst_class_e classify(input logic [31:0] inst_v, input logic upper_en);
        inst_class_e cls_v;
        cls_v = CL_ILLEGAL;
        case (inst_v[6:0])
            OP_R:            cls_v = CL_R;
            OP_IALU:         cls_v = CL_IALU;
            OP_LOAD:         cls_v = (inst_v[14:12] == F3_WORD) ? CL_LOAD  : CL_ILLEGAL;
            OP_STORE:        cls_v = (inst_v[14:12] == F3_WORD) ? CL_STORE : CL_ILLEGAL;
            OP_BRANCH:       cls_v = CL_BRANCH;
            OP_JAL:          cls_v = CL_JAL;
            OP_JALR:         cls_v = CL_JALR;
            OP_LUI, OP_AUIPC: cls_v = upper_en ? CL_UPPER : CL_ILLEGAL;
            default:         cls_v = CL_ILLEGAL;
        endcase
        return cls_v;
    endfunction

endpackage

// File: rtl/mmio_decoder.sv
// mmio_decoder: flags an address that falls inside the MMIO window
// IO_BASE .. IO_BASE + 2**IO_ADDR_BITS - 1.
module mmio_decoder #(
    parameter logic [31:0] IO_BASE      = 32'hFFFF_FC00,
    parameter int          IO_ADDR_BITS = 10
) (
    input  logic [31:0] addr,
    output logic        hit
);

    // Offset bits inside the window take no part in the match.
    logic unused_offset_s;
    assign unused_offset_s = ^addr[IO_ADDR_BITS-1:0];

    assign hit = (addr[31:IO_ADDR_BITS] == IO_BASE[31:IO_ADDR_BITS]);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB/TRAP control FSM for a
// multicycle RV32 subset datapath with memory-latency and MMIO handshake
// support. Optional feature macro: LUI_AUIPC_EN (LUI/AUIPC legal, pass-immediate).
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE      = 32'hFFFF_FC00,
    parameter int          IO_ADDR_BITS = 10,
    parameter int          MEM_LAT      = 1,
    parameter int          IO_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic [31:0] alu_result,
    input  logic        br_taken,
    input  logic        io_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        io_read,
    output logic        io_write,
    output logic        mem_or_io_to_reg,
    output logic        alu_src,
    output logic        branch,
    output logic        jump,
    output logic [1:0]  alu_op,
    output logic [2:0]  branch_type,
    output logic [2:0]  state,
    output logic        trap,
    output logic        io_err
);

`ifdef LUI_AUIPC_EN
    localparam logic UPPER_EN = 1'b1;
`else
    localparam logic UPPER_EN = 1'b0;
`endif

    // One counter serves both memory latency and IO timeout; it is wide
    // enough to reach the larger limit without wrapping.
    localparam int WAIT_MAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              io_hit_r;
    logic              io_hit_next_s;
    logic              trap_r;
    logic              io_err_r;
    logic              set_trap_s;
    logic              set_io_err_s;

    inst_class_e       cls_s;
    logic              hit_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              lat_last_s;
    logic              io_last_s;
    logic              mem_exit_s;
    logic              alu_src_s;
    logic [1:0]        alu_op_s;

    mmio_decoder #(
        .IO_BASE      (IO_BASE),
        .IO_ADDR_BITS (IO_ADDR_BITS)
    ) u_mmio_decoder (
        .addr (alu_result),
        .hit  (hit_s)
    );

    assign cls_s      = classify(inst, UPPER_EN);
    assign is_load_s  = (cls_s == CL_LOAD);
    assign is_store_s = (cls_s == CL_STORE);
    assign lat_last_s = (cnt_r == MEM_LAST);
    assign io_last_s  = (cnt_r == IO_LAST);
    // io_ready on the final timeout cycle still counts as a completed access.
    assign mem_exit_s = io_hit_r ? (io_ready || io_last_s) : lat_last_s;

    assign state  = state_r;
    assign trap   = trap_r;
    assign io_err = io_err_r;

    // Next-state, wait-counter and error-flag set logic
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        io_hit_next_s = io_hit_r;
        set_trap_s    = 1'b0;
        set_io_err_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (lat_last_s) begin
                    state_next_s = ST_DECODE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DECODE: begin
                if (cls_s == CL_ILLEGAL) begin
                    state_next_s = ST_TRAP;
                    set_trap_s   = 1'b1;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                io_hit_next_s = hit_s;
                case (cls_s)
                    CL_LOAD, CL_STORE: state_next_s = ST_MEM;
                    CL_BRANCH:         state_next_s = ST_FETCH;
                    default:           state_next_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_exit_s) begin
                    state_next_s = is_load_s ? ST_WB : ST_FETCH;
                    cnt_next_s   = CNT_ZERO;
                    set_io_err_s = io_hit_r && !io_ready;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            ST_WB: begin
                state_next_s = ST_FETCH;
            end
            ST_TRAP: begin
                state_next_s = ST_TRAP;
            end
            default: begin
                state_next_s = ST_FETCH;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // ALU operand and operation select for the current instruction class
    always_comb begin
        alu_src_s = 1'b0;
        alu_op_s  = ALU_ADD;
        case (cls_s)
            CL_R:      alu_op_s  = ALU_FUNCT;
            CL_BRANCH: alu_op_s  = ALU_CMP;
            CL_IALU, CL_LOAD, CL_STORE, CL_JALR: alu_src_s = 1'b1;
            CL_UPPER: begin
                alu_src_s = 1'b1;
                alu_op_s  = ALU_PASS;
            end
            default: begin
                alu_src_s = 1'b0;
                alu_op_s  = ALU_ADD;
            end
        endcase
    end

    // Strobe and control decode; everything defaults low so nothing leaks
    // outside the state that owns it
    always_comb begin
        pc_write         = 1'b0;
        ir_write         = 1'b0;
        reg_write        = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        io_read          = 1'b0;
        io_write         = 1'b0;
        mem_or_io_to_reg = 1'b0;
        alu_src          = 1'b0;
        branch           = 1'b0;
        jump             = 1'b0;
        alu_op           = ALU_ADD;
        branch_type      = 3'b000;
        case (state_r)
            ST_FETCH: begin
                // rst_n gating keeps ir_write quiet while reset is held when MEM_LAT is 1.
                ir_write = lat_last_s && rst_n;
            end
            ST_DECODE: begin
                branch_type = (cls_s == CL_BRANCH) ? inst[14:12] : 3'b000;
            end
            ST_EXEC: begin
                alu_src     = alu_src_s;
                alu_op      = alu_op_s;
                branch      = (cls_s == CL_BRANCH);
                pc_write    = (cls_s == CL_BRANCH) && br_taken;
                jump        = (cls_s == CL_JAL) || (cls_s == CL_JALR);
                branch_type = (cls_s == CL_BRANCH) ? inst[14:12] : 3'b000;
            end
            ST_MEM: begin
                alu_src = alu_src_s;
                alu_op  = alu_op_s;
                if (io_hit_r) begin
                    io_read  = is_load_s;
                    io_write = is_store_s;
                end else begin
                    mem_read  = is_load_s;
                    mem_write = is_store_s;
                end
                pc_write = is_store_s && mem_exit_s;
            end
            ST_WB: begin
                alu_src   = alu_src_s;
                alu_op    = alu_op_s;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                // A timed-out IO load still selects the IO read path; the
                // datapath read latch saw no io_ready and holds zero.
                mem_or_io_to_reg = is_load_s;
            end
            ST_TRAP: begin
                pc_write = 1'b0;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // FSM state, wait counter and MMIO hit latched in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_FETCH;
            cnt_r    <= CNT_ZERO;
            io_hit_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            io_hit_r <= io_hit_next_s;
        end
    end

    // Sticky trap and IO-error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_r   <= 1'b0;
            io_err_r <= 1'b0;
        end else begin
            trap_r   <= trap_r | set_trap_s;
            io_err_r <= io_err_r | set_io_err_s;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench. Each instruction
// pushes its expected per-cycle output vector (plus the io_ready/br_taken
// to apply that cycle) into a queue; the drain loop applies inputs, samples
// on the falling edge and compares against the popped expectation.
module tb_multicycle_controller;

    localparam int MEM_LAT    = 2;
    localparam int IO_TIMEOUT = 8;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       io_read;
        logic       io_write;
        logic       mem_or_io_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic [2:0] branch_type;
        logic [2:0] state;
        logic       trap;
        logic       io_err;
    } obs_t;

    typedef struct {
        logic rdy;
        logic tkn;
        obs_t exp;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic        br_taken;
    logic        io_ready;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write;
    logic        io_read, io_write, mem_or_io_to_reg, alu_src, branch, jump;
    logic [1:0]  alu_op;
    logic [2:0]  branch_type;
    logic [2:0]  state;
    logic        trap, io_err;

    obs_t obs_s;
    ent_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_trap   = 1'b0;
    logic exp_io_err = 1'b0;

    multicycle_controller #(
        .IO_BASE      (32'hFFFF_FC00),
        .IO_ADDR_BITS (10),
        .MEM_LAT      (MEM_LAT),
        .IO_TIMEOUT   (IO_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .inst             (inst),
        .alu_result       (alu_result),
        .br_taken         (br_taken),
        .io_ready         (io_ready),
        .pc_write         (pc_write),
        .ir_write         (ir_write),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .io_read          (io_read),
        .io_write         (io_write),
        .mem_or_io_to_reg (mem_or_io_to_reg),
        .alu_src          (alu_src),
        .branch           (branch),
        .jump             (jump),
        .alu_op           (alu_op),
        .branch_type      (branch_type),
        .state            (state),
        .trap             (trap),
        .io_err           (io_err)
    );

    assign obs_s = {pc_write, ir_write, reg_write, mem_read, mem_write, io_read, io_write,
                    mem_or_io_to_reg, alu_src, branch, jump, alu_op, branch_type, state,
                    trap, io_err};

    always #5 clk = ~clk;

    function automatic obs_t blank(input logic [2:0] st);
        obs_t e;
        e        = '0;
        e.state  = st;
        e.trap   = exp_trap;
        e.io_err = exp_io_err;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t e);
        checks++;
        assert (obs_s === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_s, e);
        end
    endtask

    task automatic push(input logic rdy, input logic tkn, input obs_t e);
        ent_t ent;
        ent.rdy = rdy;
        ent.tkn = tkn;
        ent.exp = e;
        sb_q.push_back(ent);
    endtask

    task automatic drain(input string tag);
        ent_t ent;
        int   n;
        n = 0;
        while (sb_q.size() > 0) begin
            ent      = sb_q.pop_front();
            io_ready = ent.rdy;
            br_taken = ent.tkn;
            @(negedge clk);
            check($sformatf("%s#%0d", tag, n), ent.exp);
            n++;
            @(posedge clk);
            #1;
        end
        io_ready = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        #1;
        exp_trap   = 1'b0;
        exp_io_err = 1'b0;
        check({tag, "_async"}, blank(S_FETCH));
        @(posedge clk);
        #1;
        check({tag, "_held"}, blank(S_FETCH));
        rst_n = 1'b1;
    endtask

    task automatic fetch_decode(input logic [31:0] i, input logic [31:0] a, input logic [2:0] bt);
        obs_t e;
        inst       = i;
        alu_result = a;
        e = blank(S_FETCH);
        push(1'b0, 1'b0, e);
        for (int k = 1; k < MEM_LAT; k++) begin
            if (k == MEM_LAT - 1) e.ir_write = 1'b1;
            push(1'b0, 1'b0, e);
        end
        e = blank(S_DECODE);
        e.branch_type = bt;
        push(1'b0, 1'b0, e);
    endtask

    task automatic run_mem(input string tag, input logic [31:0] i, input logic [31:0] a,
                           input logic ld, input logic io, input int ready_at);
        obs_t e;
        int   n;
        fetch_decode(i, a, 3'b000);
        e = blank(S_EXEC);
        e.alu_src = 1'b1;
        push(1'b0, 1'b0, e);
        n = io ? ((ready_at > 0) ? ready_at : IO_TIMEOUT) : MEM_LAT;
        for (int k = 1; k <= n; k++) begin
            e = blank(S_MEM);
            e.alu_src = 1'b1;
            if (io) begin
                e.io_read  = ld;
                e.io_write = !ld;
            end else begin
                e.mem_read  = ld;
                e.mem_write = !ld;
            end
            e.pc_write = !ld && (k == n);
            push((io && (k == ready_at)) ? 1'b1 : 1'b0, 1'b0, e);
        end
        if (io && (ready_at == 0)) exp_io_err = 1'b1;
        if (ld) begin
            e = blank(S_WB);
            e.alu_src          = 1'b1;
            e.reg_write        = 1'b1;
            e.pc_write         = 1'b1;
            e.mem_or_io_to_reg = 1'b1;
            push(1'b0, 1'b0, e);
        end
        drain(tag);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] i, input logic src,
                           input logic [1:0] op, input logic jmp);
        obs_t e;
        fetch_decode(i, 32'h0000_0040, 3'b000);
        e = blank(S_EXEC);
        e.alu_src = src;
        e.alu_op  = op;
        e.jump    = jmp;
        push(1'b0, 1'b0, e);
        e = blank(S_WB);
        e.alu_src   = src;
        e.alu_op    = op;
        e.reg_write = 1'b1;
        e.pc_write  = 1'b1;
        push(1'b0, 1'b0, e);
        drain(tag);
    endtask

    task automatic run_branch(input string tag, input logic [31:0] i, input logic [2:0] bt,
                              input logic taken);
        obs_t e;
        fetch_decode(i, 32'h0000_0000, bt);
        e = blank(S_EXEC);
        e.branch      = 1'b1;
        e.alu_op      = 2'b01;
        e.branch_type = bt;
        e.pc_write    = taken;
        push(1'b0, taken, e);
        drain(tag);
    endtask

    task automatic run_trap(input string tag, input logic [31:0] i);
        fetch_decode(i, 32'h0000_0000, 3'b000);
        exp_trap = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(k[0], k[1], blank(S_TRAP));
        end
        drain(tag);
    endtask

    initial begin
        obs_t e;
        clk        = 1'b0;
        rst_n      = 1'b1;
        inst       = 32'h0000_0013;
        alu_result = 32'h0000_0000;
        br_taken   = 1'b0;
        io_ready   = 1'b0;
        #1;
        do_reset("reset");

        // lw x1,0(x2) to memory: 7 cycles, two mem_read cycles
        run_mem("lw_mem", 32'h0001_2083, 32'h0000_0100, 1'b1, 1'b0, 0);
        // sw x1,64(x2) to memory
        run_mem("sw_mem", 32'h0411_2023, 32'h0000_0200, 1'b0, 1'b0, 0);
        // sw to MMIO, io_ready on the fifth io_write cycle
        run_mem("sw_io", 32'h0411_2023, 32'hFFFF_FC40, 1'b0, 1'b1, 5);
        // lw from MMIO, io_ready exactly at the timeout cycle: success
        run_mem("lw_io_edge", 32'h0001_2083, 32'hFFFF_FC10, 1'b1, 1'b1, IO_TIMEOUT);
        // lw from MMIO, io_ready never arrives: io_err and one write-back
        run_mem("lw_io_tmo", 32'h0001_2083, 32'hFFFF_FC10, 1'b1, 1'b1, 0);

        run_alu("add", 32'h0020_81B3, 1'b0, 2'b10, 1'b0);
        run_alu("addi", 32'h0050_0093, 1'b1, 2'b00, 1'b0);
        run_alu("jal", 32'h0080_00EF, 1'b0, 2'b00, 1'b1);
        run_alu("jalr", 32'h0000_80E7, 1'b1, 2'b00, 1'b1);

        run_branch("beq_nt", 32'h0020_8463, 3'b000, 1'b0);
        run_branch("beq_t", 32'h0020_8463, 3'b000, 1'b1);
        run_branch("bne_t", 32'h0020_9463, 3'b001, 1'b1);

        // Store aborted by reset in its final MEM cycle
        fetch_decode(32'h0411_2023, 32'h0000_0300, 3'b000);
        e = blank(S_EXEC);
        e.alu_src = 1'b1;
        push(1'b0, 1'b0, e);
        e = blank(S_MEM);
        e.alu_src   = 1'b1;
        e.mem_write = 1'b1;
        push(1'b0, 1'b0, e);
        drain("sw_abort");
        e.pc_write = 1'b1;
        check("sw_abort_mem2", e);
        do_reset("rst_mid_mem");
        run_mem("lw_after_rst", 32'h0001_2083, 32'h0000_0100, 1'b1, 1'b0, 0);

        // lb (funct3=000) is not supported
        run_trap("lb_trap", 32'h0001_0083);
        do_reset("rst_trap");
        run_alu("addi_after_trap", 32'h0050_0093, 1'b1, 2'b00, 1'b0);

        // lui x1,1
`ifdef LUI_AUIPC_EN
        run_alu("lui", 32'h0000_10B7, 1'b1, 2'b11, 1'b0);
`else
        run_trap("lui_trap", 32'h0000_10B7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
